// File: rtl/step_dir_pulse_gen.sv
// step_dir_pulse_gen: turns queued move commands (direction, step count, step period)
// into a registered STEP/DIR pin pair with guaranteed DIR setup time and STEP pulse width.
// Optional feature macro: STEP_GEN_HALT_EN adds a halt input that stops a move early.
module step_dir_pulse_gen #(
   parameter int STEPS_W       = 32,
   parameter int PERIOD_W      = 24,
   parameter int PULSE_W_CYC   = 16,
   parameter int DIR_SETUP_CYC = 8
) (
   input  logic                clk,
   input  logic                reset,
`ifdef STEP_GEN_HALT_EN
   input  logic                halt,
`endif
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_dir,
   input  logic [STEPS_W-1:0]  cmd_steps,
   input  logic [PERIOD_W-1:0] cmd_period,
   output logic                step,
   output logic                dir,
   output logic                busy,
   output logic                move_done,
   output logic [STEPS_W-1:0]  steps_remaining
);

   // One extra bit so the period clamp and low-phase length never overflow.
   localparam int CW = PERIOD_W + 1;
   localparam logic [CW-1:0] PW_LEN     = CW'(PULSE_W_CYC);
   localparam logic [CW-1:0] PW_LAST    = CW'(PULSE_W_CYC - 1);
   localparam logic [CW-1:0] MIN_PERIOD = CW'(PULSE_W_CYC + 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETUP, PULSE_HI, PULSE_LO} state_t;

   state_t              state, state_n;
   logic                step_n, dir_n, busy_n, move_done_n;
   logic [STEPS_W-1:0]  rem_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [CW-1:0]       low_len, low_len_n;
   logic                halt_q, halt_q_n;
   logic                halt_i;
   logic                accept;
   logic [CW-1:0]       period_ext, period_eff, low_eff;
   logic                stop_req;

`ifdef STEP_GEN_HALT_EN
   assign halt_i = halt;
`else
   assign halt_i = 1'b0;
`endif

   assign cmd_ready = (state == IDLE) && !halt_i;
   assign accept    = cmd_valid && cmd_ready;

   // Effective period is clamped so the low phase is always at least one cycle.
   assign period_ext = {1'b0, cmd_period};
   assign period_eff = (period_ext < MIN_PERIOD) ? MIN_PERIOD : period_ext;
   assign low_eff    = period_eff - PW_LEN;
   assign stop_req   = halt_q || halt_i;

   // Next-state and next-output logic for the move sequencer.
   always_comb begin
      state_n     = state;
      step_n      = step;
      dir_n       = dir;
      move_done_n = 1'b0;
      rem_n       = steps_remaining;
      cnt_n       = cnt;
      low_len_n   = low_len;
      halt_q_n    = halt_q;
      unique case (state)
         IDLE: begin
            if (accept) begin
               halt_q_n  = 1'b0;
               low_len_n = low_eff;
               cnt_n     = '0;
               if (cmd_steps == '0) begin
                  move_done_n = 1'b1;
                  rem_n       = '0;
               end else if (cmd_dir != dir) begin
                  dir_n   = cmd_dir;
                  state_n = SETUP;
                  rem_n   = cmd_steps;
               end else begin
                  state_n = PULSE_HI;
                  step_n  = 1'b1;
                  rem_n   = cmd_steps - STEPS_W'(1);
               end
            end
         end
         SETUP: begin
            if (halt_i) begin
               state_n     = IDLE;
               move_done_n = 1'b1;
               cnt_n       = '0;
            end else if (cnt == SETUP_LAST) begin
               state_n = PULSE_HI;
               step_n  = 1'b1;
               cnt_n   = '0;
               rem_n   = (steps_remaining != '0) ? steps_remaining - STEPS_W'(1) : '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         PULSE_HI: begin
            // A halt here lets the current pulse and its low phase finish.
            if (halt_i) halt_q_n = 1'b1;
            if (cnt == PW_LAST) begin
               state_n = PULSE_LO;
               step_n  = 1'b0;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         PULSE_LO: begin
            if (cnt == low_len - CW'(1)) begin
               cnt_n = '0;
               if (steps_remaining != '0 && !stop_req) begin
                  state_n = PULSE_HI;
                  step_n  = 1'b1;
                  rem_n   = steps_remaining - STEPS_W'(1);
               end else begin
                  state_n     = IDLE;
                  move_done_n = 1'b1;
                  halt_q_n    = 1'b0;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   // State and output registers; reset drops STEP immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         step            <= 1'b0;
         dir             <= 1'b0;
         busy            <= 1'b0;
         move_done       <= 1'b0;
         steps_remaining <= '0;
         cnt             <= '0;
         low_len         <= '0;
         halt_q          <= 1'b0;
      end else begin
         state           <= state_n;
         step            <= step_n;
         dir             <= dir_n;
         busy            <= busy_n;
         move_done       <= move_done_n;
         steps_remaining <= rem_n;
         cnt             <= cnt_n;
         low_len         <= low_len_n;
         halt_q          <= halt_q_n;
      end
   end

endmodule

// File: tb/tb_step_dir_pulse_gen.sv
// Bench for step_dir_pulse_gen: directed and random move commands checked cycle by cycle
// against an arithmetic model of the expected STEP/DIR waveform.
module tb_step_dir_pulse_gen;
   localparam int STEPS_W = 32;
   localparam int PERIOD_W = 24;
   localparam int PW = 16;
   localparam int DS = 8;

   logic                clk = 1'b0;
   logic                reset;
   logic                cmd_valid, cmd_ready, cmd_dir;
   logic [STEPS_W-1:0]  cmd_steps;
   logic [PERIOD_W-1:0] cmd_period;
   logic                step, dir, busy, move_done;
   logic [STEPS_W-1:0]  steps_remaining;
`ifdef STEP_GEN_HALT_EN
   logic                halt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic model_dir = 1'b0;

   typedef struct packed {
      logic        st;
      logic        bz;
      logic        dn;
      logic [31:0] rem;
   } exp_t;

   step_dir_pulse_gen #(.STEPS_W(STEPS_W), .PERIOD_W(PERIOD_W),
                        .PULSE_W_CYC(PW), .DIR_SETUP_CYC(DS)) dut (
      .clk(clk), .reset(reset),
`ifdef STEP_GEN_HALT_EN
      .halt(halt),
`endif
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_steps(cmd_steps), .cmd_period(cmd_period), .step(step), .dir(dir),
      .busy(busy), .move_done(move_done), .steps_remaining(steps_remaining));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Expected outputs k cycles after acceptance: optional DIR setup window,
   // then `steps` periods of PW high / (p-PW) low, then one move_done cycle.
   function automatic exp_t exp_at(int k, int steps, int p, int setup);
      exp_t e;
      int i, ph;
      if (steps == 0 || k >= setup + steps * p) begin
         e = '{st: 1'b0, bz: 1'b0, dn: 1'b1, rem: 32'd0};
      end else if (k < setup) begin
         e = '{st: 1'b0, bz: 1'b1, dn: 1'b0, rem: 32'(steps)};
      end else begin
         i  = (k - setup) / p;
         ph = (k - setup) % p;
         e  = '{st: (ph < PW), bz: 1'b1, dn: 1'b0, rem: 32'(steps - 1 - i)};
      end
      return e;
   endfunction

   task automatic chk_k(int k, int steps, int p, int setup);
      exp_t e;
      e = exp_at(k, steps, p, setup);
      chk("step", 64'(step), 64'(e.st));
      chk("busy", 64'(busy), 64'(e.bz));
      chk("move_done", 64'(move_done), 64'(e.dn));
      chk("steps_remaining", 64'(steps_remaining), 64'(e.rem));
      chk("dir", 64'(dir), 64'(model_dir));
      chk("cmd_ready", 64'(cmd_ready), 64'(!e.bz));
   endtask

   // Called at a negedge with the block idle; returns at the negedge of the move_done cycle.
   task automatic run_cmd(input logic d, input int steps, input int period);
      int p, setup, last;
      p     = (period < PW + 1) ? PW + 1 : period;
      setup = (steps != 0 && d != model_dir) ? DS : 0;
      last  = (steps == 0) ? 0 : setup + steps * p;
      chk("ready_before_accept", 64'(cmd_ready), 64'd1);
      cmd_valid  = 1'b1;
      cmd_dir    = d;
      cmd_steps  = 32'(steps);
      cmd_period = 24'(period);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      if (steps != 0) model_dir = d;
      for (int k = 0; k <= last; k++) begin
         if (k > 0) @(negedge clk);
         chk_k(k, steps, p, setup);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_step", 64'(step), 64'd0);
         chk("idle_busy", 64'(busy), 64'd0);
         chk("idle_done", 64'(move_done), 64'd0);
         chk("idle_ready", 64'(cmd_ready), 64'd1);
      end
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; cmd_period = '0;
`ifdef STEP_GEN_HALT_EN
      halt = 1'b0;
`endif
      #1;
      chk("rst_step", 64'(step), 64'd0);
      chk("rst_dir", 64'(dir), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(move_done), 64'd0);
      chk("rst_rem", 64'(steps_remaining), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle_cycles(2);

      // Directed: plain move, dir change with setup, period clamp, zero-step,
      // then same-dir commands back to back.
      run_cmd(1'b0, 3, 40);
      idle_cycles(1);
      run_cmd(1'b1, 1, 100);
      run_cmd(1'b1, 2, 5);
      run_cmd(1'b0, 0, 7);
      run_cmd(1'b1, 2, 20);
      run_cmd(1'b1, 2, 18);
      idle_cycles(1);

      // Random commands with random gaps (gap 0 = accepted in the move_done cycle).
      for (int n = 0; n < 30; n++) begin
         run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 45)));
         idle_cycles(int'($urandom_range(0, 2)));
      end

      // Asynchronous reset in the middle of a high pulse.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 32'd5; cmd_period = 24'd30;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (DS + 3) @(negedge clk);
      chk("pre_rst_step", 64'(step), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_step", 64'(step), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_rem", 64'(steps_remaining), 64'd0);
      chk("midrst_dir", 64'(dir), 64'd0);
      model_dir = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      idle_cycles(2);
      run_cmd(1'b0, 2, 20);

`ifdef STEP_GEN_HALT_EN
      // Halt during the DIR setup window: no pulse, unsent count held.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = ~model_dir; cmd_steps = 32'd3; cmd_period = 24'd20;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      model_dir = ~model_dir;
      @(negedge clk);
      halt = 1'b1;
      @(negedge clk);
      chk("hs_busy", 64'(busy), 64'd0);
      chk("hs_done", 64'(move_done), 64'd1);
      chk("hs_step", 64'(step), 64'd0);
      chk("hs_rem", 64'(steps_remaining), 64'd3);
      chk("hs_ready", 64'(cmd_ready), 64'd0);
      chk("hs_dir", 64'(dir), 64'(model_dir));
      halt = 1'b0;
      @(negedge clk);
      chk("hs_ready_after", 64'(cmd_ready), 64'd1);
      chk("hs_rem_after", 64'(steps_remaining), 64'd3);

      // Halt during pulse 2 of 10: pulse 2 finishes fully, then stop with 8 unsent.
      cmd_valid = 1'b1; cmd_dir = model_dir; cmd_steps = 32'd10; cmd_period = 24'd20;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         chk_k(k, 10, 20, 0);
         if (k == 23) halt = 1'b1;
      end
      @(negedge clk);
      chk("hp_step", 64'(step), 64'd0);
      chk("hp_busy", 64'(busy), 64'd0);
      chk("hp_done", 64'(move_done), 64'd1);
      chk("hp_rem", 64'(steps_remaining), 64'd8);
      chk("hp_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("hp_no_pulse", 64'(step), 64'd0);
      chk("hp_ready_held", 64'(cmd_ready), 64'd0);
      halt = 1'b0;
      @(negedge clk);
      chk("hp_ready_after", 64'(cmd_ready), 64'd1);
      chk("hp_rem_after", 64'(steps_remaining), 64'd8);
      chk("hp_done_after", 64'(move_done), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
